// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the bit-serial subtractor.
// The master drives the request and operands; the slave returns status, results and its FSM state for debug.
interface serial_subtractor_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] d;
    logic             b_out;
    logic             v_out;
    logic [1:0]       state_dbg;

    // Handshake: a request transfers on a rising edge where start=1 and ready=1.
    // a/b/b_in are captured on that edge only. done is a one-cycle pulse with d/b_out/v_out valid.
    // The results then hold until the next completion or reset.
    modport master (
        output start, a, b, b_in,
        input  ready, busy, done, d, b_out, v_out, state_dbg
    );

    modport slave (
        input  start, a, b, b_in,
        output ready, busy, done, d, b_out, v_out, state_dbg
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: d = a - b - b_in, one full-subtractor step per clock, LSB first.
// Result flags are latched at the final bit and held until the next completion or reset.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input logic              Clock,
    input logic              Resetn,
    serial_subtractor_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] d_q;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             b_out_q;
    logic             v_out_q;

    logic             di;
    logic             br_n;
    logic             last;
    logic             accept;
    logic [WIDTH-1:0] res_n;

    always_comb begin
        di     = a_sr[0] ^ b_sr[0] ^ br;
        br_n   = (~a_sr[0] & b_sr[0]) | (~a_sr[0] & br) | (b_sr[0] & br);
        last   = (cnt == CW'(WIDTH - 1));
        accept = bus.start && (state != SHIFT);
        res_n  = {di, res_sr[WIDTH-1:1]};
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            res_sr  <= '0;
            d_q     <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            b_out_q <= 1'b0;
            v_out_q <= 1'b0;
        end else begin
            case (state)
                SHIFT: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_n;
                    br     <= br_n;
                    cnt    <= cnt + CW'(1);
                    // br here is the borrow into the MSB; br_n is the borrow out of it.
                    if (last) begin
                        state   <= DONE;
                        d_q     <= res_n;
                        b_out_q <= br_n;
                        v_out_q <= br ^ br_n;
                    end
                end
                default: begin
                    if (accept) begin
                        state  <= SHIFT;
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        br     <= bus.b_in;
                        cnt    <= '0;
                    end else begin
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.ready     = (state != SHIFT);
    assign bus.busy      = (state == SHIFT);
    assign bus.done      = (state == DONE);
    assign bus.d         = d_q;
    assign bus.b_out     = b_out_q;
    assign bus.v_out     = v_out_q;
    assign bus.state_dbg = state;
endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: randomized and exhaustive operations against an arithmetic reference,
// with expected results queued at issue time and checked by an independent done monitor.
module tb_serial_subtractor;
    localparam int WIDTH = 4;
    localparam int LAT   = WIDTH;

    logic Clock;
    logic Resetn;
    int   cycle;
    int   n_tests;
    int   n_fail;

    logic [WIDTH+1:0] exp_q[$];
    int               cyc_q[$];

    serial_subtractor_if #(.WIDTH(WIDTH)) ifc ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (ifc.slave)
    );

    // ---------------- clock / reset ----------------
    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) cycle <= cycle + 1;

    // ---------------- reference model ----------------
    function automatic logic [WIDTH+1:0] model(input int a, input int b, input int bin);
        int               diff;
        int               sa;
        int               sb;
        int               sd;
        logic [WIDTH-1:0] dd;
        logic             bo;
        logic             v;
        diff = a - b - bin;
        sa   = (a >= (1 << (WIDTH - 1))) ? a - (1 << WIDTH) : a;
        sb   = (b >= (1 << (WIDTH - 1))) ? b - (1 << WIDTH) : b;
        sd   = sa - sb - bin;
        dd   = diff[WIDTH-1:0];
        bo   = (diff < 0);
        v    = (sd < -(1 << (WIDTH - 1))) || (sd > (1 << (WIDTH - 1)) - 1);
        return {v, bo, dd};
    endfunction

    // ---------------- driver tasks ----------------
    // Called and returning at a negedge.
    task automatic issue(input int a, input int b, input int bin, input bit push, input bit hold);
        int k;
        k = 0;
        while (!ifc.ready && k < 50) begin
            @(negedge Clock);
            k++;
        end
        if (k >= 50) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: ready=%0b required=1", ifc.ready);
        end
        ifc.start = 1'b1;
        ifc.a     = WIDTH'(a);
        ifc.b     = WIDTH'(b);
        ifc.b_in  = 1'(bin);
        if (push) begin
            exp_q.push_back(model(a, b, bin));
            cyc_q.push_back(cycle + 1 + LAT);
        end
        @(posedge Clock);
        @(negedge Clock);
        if (!hold) ifc.start = 1'b0;
        ifc.a    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        ifc.b    = WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
        ifc.b_in = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 200) begin
            @(negedge Clock);
            k++;
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: pending=%0d required=0", exp_q.size());
            exp_q.delete();
            cyc_q.delete();
        end
        repeat (2) @(negedge Clock);
    endtask

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge Clock) begin
        if (Resetn === 1'b1 && n_tests >= 0) begin
            n_tests++;
            if (ifc.ready !== !ifc.busy) begin
                n_fail++;
                $display("FAIL ready_busy: ready=%0b busy=%0b", ifc.ready, ifc.busy);
            end
            if (ifc.done === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_done: cycle=%0d d=%0h", cycle, ifc.d);
                end else begin
                    logic [WIDTH+1:0] exp;
                    int               ec;
                    exp = exp_q.pop_front();
                    ec  = cyc_q.pop_front();
                    if ({ifc.v_out, ifc.b_out, ifc.d} !== exp) begin
                        n_fail++;
                        $display("FAIL result: actual v=%0b bo=%0b d=%0h required v=%0b bo=%0b d=%0h",
                                 ifc.v_out, ifc.b_out, ifc.d, exp[WIDTH+1], exp[WIDTH], exp[WIDTH-1:0]);
                    end
                    n_tests++;
                    if (cycle != ec) begin
                        n_fail++;
                        $display("FAIL latency: done_cycle=%0d required=%0d", cycle, ec);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        cycle    = 0;
        n_tests  = 0;
        n_fail   = 0;
        Resetn   = 1'b0;
        ifc.start = 1'b0;
        ifc.a    = '0;
        ifc.b    = '0;
        ifc.b_in = 1'b0;
        repeat (3) @(negedge Clock);
        check("reset_ready", int'(ifc.ready), 1);
        check("reset_busy",  int'(ifc.busy),  0);
        check("reset_done",  int'(ifc.done),  0);
        check("reset_d",     int'(ifc.d),     0);
        check("reset_bout",  int'(ifc.b_out), 0);
        check("reset_vout",  int'(ifc.v_out), 0);
        Resetn = 1'b1;
        @(negedge Clock);

        // directed cases
        issue(9, 3, 0, 1'b1, 1'b0); drain();
        check("d_9m3", int'(ifc.d), 6);
        issue(3, 9, 0, 1'b1, 1'b0); drain();
        issue(0, 0, 1, 1'b1, 1'b0); drain();
        issue(8, 1, 0, 1'b1, 1'b0); drain();
        issue(5, 5, 0, 1'b1, 1'b0); drain();

        // start pulsed during SHIFT is ignored
        issue(12, 7, 1, 1'b1, 1'b0);
        ifc.start = 1'b1;
        ifc.a     = 4'd1;
        ifc.b     = 4'd2;
        @(negedge Clock);
        ifc.start = 1'b0;
        drain();

        // back-to-back with start held high
        for (int i = 0; i < 8; i++)
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b1, i != 7);
        drain();

        // reset two cycles after accept aborts the operation
        issue(9, 3, 0, 1'b1, 1'b0); drain();
        issue(7, 2, 0, 1'b0, 1'b0);
        @(negedge Clock);
        Resetn = 1'b0;
        @(negedge Clock);
        check("abort_d",     int'(ifc.d),     0);
        check("abort_ready", int'(ifc.ready), 1);
        check("abort_done",  int'(ifc.done),  0);
        check("abort_busy",  int'(ifc.busy),  0);
        Resetn = 1'b1;
        repeat (8) @(negedge Clock);
        issue(3, 9, 0, 1'b1, 1'b0); drain();

        // exhaustive sweep, randomly mixing idle gaps and back-to-back accepts
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int bin = 0; bin < 2; bin++)
                    issue(a, b, bin, 1'b1, bit'($urandom_range(0, 1)) && !(a == 15 && b == 15 && bin == 1));
        drain();

        // random tail
        for (int i = 0; i < 100; i++)
            issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b1, i != 99);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
